// File: rtl/mod_counter_ctrl.sv
// rtl/mod_counter_ctrl.sv - programmable modulo-N counter controller with prescaler, one-shot mode and wrap reporting
module mod_counter_ctrl #(
    parameter int WIDTH = 8,
    parameter int PW    = 4,
    parameter int WRAPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [PW-1:0]    cfg_presc,
    input  logic             cfg_oneshot,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             irq,
    output logic [WRAPW-1:0] wraps,
    output logic             cfg_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;

    logic [1:0]       state;
    logic [PW-1:0]    psc_cnt;
    logic [WIDTH-1:0] period_r;
    logic [PW-1:0]    presc_r;
    logic             oneshot_r;

    logic cfg_ok;
    logic run_en;
    logic tick;
    logic wrap;

    // stop and start override counting, so a tick only happens on an undisturbed RUN cycle
    always_comb begin
        cfg_ok = cfg_we && (state == S_IDLE) && (cfg_period != '0);
        run_en = (state == S_RUN) && !stop && !start && !pause;
        tick   = run_en && (psc_cnt == presc_r);
        wrap   = tick && (count == period_r - WIDTH'(1));
    end

    assign busy = (state == S_RUN) || (state == S_PAUSED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            count     <= '0;
            psc_cnt   <= '0;
            period_r  <= WIDTH'(2);
            presc_r   <= '0;
            oneshot_r <= 1'b0;
            tc        <= 1'b0;
            irq       <= 1'b0;
            wraps     <= '0;
            cfg_err   <= 1'b0;
        end else begin
            tc      <= wrap;
            cfg_err <= cfg_we && !cfg_ok;

            if (cfg_ok) begin
                period_r  <= cfg_period;
                presc_r   <= cfg_presc;
                oneshot_r <= cfg_oneshot;
            end

            // a wrap on the same cycle as irq_clr keeps the flag set
            if (wrap)
                irq <= 1'b1;
            else if (irq_clr)
                irq <= 1'b0;

            if (stop) begin
                state   <= S_IDLE;
                count   <= '0;
                psc_cnt <= '0;
            end else if (start) begin
                state   <= S_RUN;
                count   <= '0;
                psc_cnt <= '0;
                wraps   <= '0;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_RUN: begin
                        if (pause) begin
                            state <= S_PAUSED;
                        end else if (tick) begin
                            psc_cnt <= '0;
                            if (wrap) begin
                                count <= '0;
                                if (wraps != '1)
                                    wraps <= wraps + WRAPW'(1);
                                if (oneshot_r)
                                    state <= S_IDLE;
                            end else begin
                                count <= count + WIDTH'(1);
                            end
                        end else begin
                            psc_cnt <= psc_cnt + PW'(1);
                        end
                    end
                    S_PAUSED: begin
                        if (!pause)
                            state <= S_RUN;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// tb/tb_mod_counter_ctrl.sv - vector table and scoreboard bench for mod_counter_ctrl
module tb_mod_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, pause, cfg_we, cfg_oneshot, irq_clr;
    logic [7:0] cfg_period;
    logic [3:0] cfg_presc;
    logic [7:0] count;
    logic       busy, tc, irq, cfg_err;
    logic [7:0] wraps;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       st, sp, pa, we;
        logic [7:0] per;
        logic [3:0] psc;
        logic       os, clr;
        logic [7:0] ec;
        logic       eb, et, ei;
        logic [7:0] ew;
        logic       ee;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    mod_counter_ctrl #(.WIDTH(8), .PW(4), .WRAPW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .cfg_we(cfg_we), .cfg_period(cfg_period), .cfg_presc(cfg_presc),
        .cfg_oneshot(cfg_oneshot), .irq_clr(irq_clr),
        .count(count), .busy(busy), .tc(tc), .irq(irq), .wraps(wraps), .cfg_err(cfg_err)
    );

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic add_vec(input logic st, sp, pa, we, input logic [7:0] per, input logic [3:0] psc,
                           input logic os, clr, input logic [7:0] ec, input logic eb, et, ei,
                           input logic [7:0] ew, input logic ee);
        vec_t v;
        v.st = st; v.sp = sp; v.pa = pa; v.we = we; v.per = per; v.psc = psc; v.os = os; v.clr = clr;
        v.ec = ec; v.eb = eb; v.et = et; v.ei = ei; v.ew = ew; v.ee = ee;
        vecs.push_back(v);
    endtask

    task automatic idle_exp(input logic [7:0] ec, input logic eb, et, ei, input logic [7:0] ew);
        add_vec(0, 0, 0, 0, 8'd0, 4'd0, 0, 0, ec, eb, et, ei, ew, 0);
    endtask

    task automatic run_vecs();
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].st; stop = vecs[i].sp; pause = vecs[i].pa; cfg_we = vecs[i].we;
            cfg_period = vecs[i].per; cfg_presc = vecs[i].psc; cfg_oneshot = vecs[i].os;
            irq_clr = vecs[i].clr;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d count", i), count, e.ec);
            chk($sformatf("v%0d busy", i), busy, e.eb);
            chk($sformatf("v%0d tc", i), tc, e.et);
            chk($sformatf("v%0d irq", i), irq, e.ei);
            chk($sformatf("v%0d wraps", i), wraps, e.ew);
            chk($sformatf("v%0d cfg_err", i), cfg_err, e.ee);
        end
        vecs.delete();
        start = 0; stop = 0; pause = 0; cfg_we = 0; irq_clr = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " count"}, count, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " tc"}, tc, 0);
        chk({tag, " irq"}, irq, 0);
        chk({tag, " wraps"}, wraps, 0);
        chk({tag, " cfg_err"}, cfg_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1; start = 0; stop = 0; pause = 0; cfg_we = 0; cfg_oneshot = 0; irq_clr = 0;
        cfg_period = 0; cfg_presc = 0;
        #12;
        chk_zero("reset");
        #10 rst = 0;

        // periodic P=5
        add_vec(0, 0, 0, 1, 8'd5, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 8'd0, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++)
            idle_exp(8'(k % 5), 1, (k % 5) == 0, k >= 5, 8'(k / 5));
        add_vec(0, 1, 0, 0, 8'd0, 4'd0, 0, 0, 0, 0, 0, 1, 2, 0);
        add_vec(0, 0, 0, 0, 8'd0, 4'd0, 0, 1, 0, 0, 0, 0, 2, 0);
        // rejected writes: zero period in IDLE, then any write while running
        add_vec(0, 0, 0, 1, 8'd0, 4'd0, 0, 0, 0, 0, 0, 0, 2, 1);
        add_vec(1, 0, 0, 0, 8'd0, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 6)
                add_vec(0, 0, 0, 1, 8'd7, 4'd3, 1, 0, 1, 1, 0, 1, 1, 1);
            else
                idle_exp(8'(k % 5), 1, (k % 5) == 0, k >= 5, 8'(k / 5));
        end
        add_vec(0, 1, 0, 0, 8'd0, 4'd0, 0, 0, 0, 0, 0, 1, 2, 0);
        add_vec(1, 1, 0, 0, 8'd0, 4'd0, 0, 0, 0, 0, 0, 1, 2, 0);
        add_vec(0, 0, 0, 0, 8'd0, 4'd0, 0, 1, 0, 0, 0, 0, 2, 0);

        // prescale 2, one-shot, P=3
        add_vec(0, 0, 0, 1, 8'd3, 4'd1, 1, 0, 0, 0, 0, 0, 2, 0);
        add_vec(1, 0, 0, 0, 8'd0, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle_exp(0, 1, 0, 0, 0);
        idle_exp(1, 1, 0, 0, 0);
        idle_exp(1, 1, 0, 0, 0);
        idle_exp(2, 1, 0, 0, 0);
        idle_exp(2, 1, 0, 0, 0);
        idle_exp(0, 0, 1, 1, 1);
        idle_exp(0, 0, 0, 1, 1);

        // pause for 7 cycles at count 4, P=10
        add_vec(0, 0, 0, 1, 8'd10, 4'd0, 0, 0, 0, 0, 0, 1, 1, 0);
        add_vec(1, 0, 0, 0, 8'd0, 4'd0, 0, 0, 0, 1, 0, 1, 0, 0);
        add_vec(0, 0, 0, 0, 8'd0, 4'd0, 0, 1, 1, 1, 0, 0, 0, 0);
        for (int k = 2; k <= 4; k++) idle_exp(8'(k), 1, 0, 0, 0);
        for (int k = 0; k < 7; k++) add_vec(0, 0, 1, 0, 8'd0, 4'd0, 0, 0, 4, 1, 0, 0, 0, 0);
        idle_exp(4, 1, 0, 0, 0);
        for (int k = 5; k <= 9; k++) idle_exp(8'(k), 1, 0, 0, 0);
        add_vec(0, 0, 0, 0, 8'd0, 4'd0, 0, 1, 0, 1, 1, 1, 1, 0);
        add_vec(0, 0, 0, 0, 8'd0, 4'd0, 0, 1, 1, 1, 0, 0, 1, 0);
        // start with pause high re-arms into RUN, pause applies next cycle
        add_vec(1, 0, 1, 0, 8'd0, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0);
        add_vec(0, 0, 1, 0, 8'd0, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle_exp(0, 1, 0, 0, 0);
        idle_exp(1, 1, 0, 0, 0);
        add_vec(0, 1, 0, 0, 8'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0);

        // P=1: tc every cycle, wraps saturates at 255
        add_vec(0, 0, 0, 1, 8'd1, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 8'd0, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 300; k++) idle_exp(0, 1, 1, 1, 8'(k > 255 ? 255 : k));
        add_vec(0, 1, 0, 0, 8'd0, 4'd0, 0, 0, 0, 0, 0, 1, 255, 0);

        // run to count 7 before an asynchronous reset
        add_vec(0, 0, 0, 1, 8'd10, 4'd0, 0, 0, 0, 0, 0, 1, 255, 0);
        add_vec(1, 0, 0, 0, 8'd0, 4'd0, 0, 0, 0, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 7; k++) idle_exp(8'(k), 1, 0, 1, 0);
        run_vecs();

        #2 rst = 1;
        #1 chk_zero("async_rst");
        #3 rst = 0;

        // default period 2 after reset
        add_vec(1, 0, 0, 0, 8'd0, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle_exp(1, 1, 0, 0, 0);
        idle_exp(0, 1, 1, 1, 1);
        idle_exp(1, 1, 0, 1, 1);
        run_vecs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_counter_ctrl.md
Name: mod_counter_ctrl

Overview:
- Programmable controller for a modulo-N counter. Holds the counter's configuration: modulus, prescale divider and one-shot/periodic mode.
- Sequences the counter through idle, run and pause states.
- Reports terminal-count events as a one-cycle strobe, a sticky interrupt flag and a saturating wrap counter.
- Sits between the register/control logic and any timing datapath that needs a reconfigurable mod-N tick source.

Parameters:
- WIDTH, 8, width of the count and modulus.
- PW, 4, width of the prescale field; divide ratio = cfg_presc+1.
- WRAPW, 8, width of the saturating wrap counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; arm the counter and count from 0.
- stop  in  1  pulse; abort to IDLE.
- pause  in  1  level; hold the count while high in RUN.
- cfg_we  in  1  configuration write strobe.
- cfg_period  in  WIDTH  modulus P; count runs 0..P-1.
- cfg_presc  in  PW  prescale; the count advances every cfg_presc+1 enabled cycles.
- cfg_oneshot  in  1  1 = stop after the first wrap; 0 = periodic.
- irq_clr  in  1  clear the sticky irq.
- count  out  WIDTH  current count value.
- busy  out  1  high in RUN or PAUSED.
- tc  out  1  one-cycle terminal-count strobe.
- irq  out  1  sticky terminal-count flag.
- wraps  out  WRAPW  number of wraps since start; saturates at all-ones.
- cfg_err  out  1  one-cycle strobe for a rejected configuration write.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, count=0, prescale counter=0, period reg=2, presc reg=0, oneshot reg=0, busy=0, tc=0, irq=0, wraps=0, cfg_err=0.
- All outputs are registered.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE; pause -> PAUSED; one-shot wrap -> IDLE.
  - PAUSED: stop -> IDLE; pause low -> RUN.
- Configuration:
  - cfg_we is accepted only in IDLE with cfg_period>=1; the registers load on that edge.
  - cfg_we while busy or with cfg_period==0: registers unchanged, cfg_err=1 for the next cycle.
- Start:
  - The edge sampling start in IDLE clears count, prescale counter and wraps; RUN begins on the next cycle.
  - start in RUN or PAUSED re-arms: same clears, state -> RUN.
- Prescaling and counting:
  - In RUN with pause low, the prescale counter increments each cycle.
  - When the prescale counter equals presc reg it returns to 0 and a tick occurs.
  - On a tick, count increments. If count==P-1, count wraps to 0 instead.
- On wrap:
  - tc=1 for exactly the following cycle, coincident with count==0.
  - irq sets.
  - wraps increments, saturating.
  - If oneshot reg=1, state -> IDLE on the same edge; count stays 0.
- P=1: every tick is a wrap and count stays 0. With presc=0, tc is high every cycle in periodic mode.
- Pause:
  - In PAUSED, count and prescale counter are frozen; no tick and no tc.
  - Resuming continues from the frozen values, with no restart.
- Stop: clears count and prescale counter to 0; wraps and irq are preserved; tc is not generated.
- Priority on simultaneous inputs: stop > start > pause.
  - stop+start in the same cycle -> IDLE.
  - start with pause high -> re-arm into RUN; pause takes effect on the next cycle.
- irq:
  - irq_clr clears it.
  - A wrap and irq_clr in the same cycle -> irq stays 1 (set wins).
- busy = (state==RUN or PAUSED).
- Reset mid-run: immediately returns every register to its reset value, including the configuration registers.

Test Plan:
- Period reset: cfg P=5, presc=0, periodic, start -> count 0,1,2,3,4,0,1…; tc high each time count returns to 0 (every 5 cycles); irq=1; wraps increments per wrap.
- Prescaler and one-shot: cfg P=3, presc=1, oneshot=1, start -> each count value held 2 cycles; single tc after 6 cycles; busy falls on the same edge; count=0; wraps=1.
- Pause: P=10 periodic; pause at count=4 for 7 cycles -> count holds 4 with no tc; release -> 5,6,…,9,0 with tc at the wrap.
- Configuration guards: cfg_we with P=0 in IDLE -> cfg_err pulse, period unchanged; cfg_we while busy -> cfg_err pulse, running period unchanged.
- Priority and irq: stop+start in the same cycle -> IDLE, busy=0; wrap coincident with irq_clr -> irq stays 1; irq_clr the next cycle -> irq=0.
- Async reset mid-run: rst pulse between clock edges at count=7 -> all outputs 0 immediately; period reg=2; start afterward -> count 0,1,0…
